// File: rtl/pwm_multi_channel.sv
// Multi-channel PWM generator sharing one N-bit timebase, edge- or center-aligned,
// with double-buffered period/duty/mode applied only at period boundaries.
module pwm_multi_channel #(
    parameter int N  = 8,
    parameter int CH = 4
) (
    input  logic            clk,
    input  logic            reset,
    input  logic            en,
    input  logic            cfg_wr,
    input  logic [N-1:0]    period,
    input  logic [CH*N-1:0] duty,
    input  logic            center,
    output logic            cfg_pending,
    output logic            period_start,
    output logic [CH-1:0]   pwm_out
);

    localparam logic [N-1:0] ONE = {{(N-1){1'b0}}, 1'b1};

    logic [N-1:0]    cnt_q, cnt_d;
    logic            dir_q, dir_d;          // 1 = counting down
    logic [N-1:0]    per_act_q;
    logic [CH*N-1:0] duty_act_q;
    logic            ctr_act_q;
    logic [N-1:0]    per_pend_q;
    logic [CH*N-1:0] duty_pend_q;
    logic            ctr_pend_q;
    logic            pend_q;
    logic            ps_q, ps_d;
    logic [CH-1:0]   pwm_q, pwm_d;
    logic            apply;

    always_comb begin
        cnt_d = '0;
        dir_d = 1'b0;
        if (en) begin
            if (!ctr_act_q || per_act_q == '0) begin
                cnt_d = (cnt_q >= per_act_q) ? '0 : cnt_q + ONE;
            end else if (!dir_q) begin
                if (cnt_q >= per_act_q) begin
                    cnt_d = per_act_q - ONE;
                    dir_d = 1'b1;
                end else begin
                    cnt_d = cnt_q + ONE;
                end
            end else begin
                cnt_d = cnt_q - ONE;
                dir_d = 1'b1;
            end
            if (cnt_d == '0) begin
                dir_d = 1'b0;
            end
        end
    end

    // With en low cnt_d is forced to 0, so this also covers the stopped case.
    assign apply = (cnt_d == '0);
    assign ps_d  = en & (cnt_q == '0);

    genvar gi;
    generate
        for (gi = 0; gi < CH; gi++) begin : g_cmp
            assign pwm_d[gi] = en & (cnt_q < duty_act_q[gi*N +: N]);
        end
    endgenerate

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            cnt_q       <= '0;
            dir_q       <= 1'b0;
            per_act_q   <= '1;
            duty_act_q  <= '0;
            ctr_act_q   <= 1'b0;
            per_pend_q  <= '0;
            duty_pend_q <= '0;
            ctr_pend_q  <= 1'b0;
            pend_q      <= 1'b0;
            ps_q        <= 1'b0;
            pwm_q       <= '0;
        end else begin
            cnt_q <= cnt_d;
            dir_q <= dir_d;
            ps_q  <= ps_d;
            pwm_q <= pwm_d;
            if (apply && pend_q) begin
                per_act_q  <= per_pend_q;
                duty_act_q <= duty_pend_q;
                ctr_act_q  <= ctr_pend_q;
            end
            // A write on a boundary edge stays pending for the following boundary.
            if (cfg_wr) begin
                per_pend_q  <= period;
                duty_pend_q <= duty;
                ctr_pend_q  <= center;
                pend_q      <= 1'b1;
            end else if (apply) begin
                pend_q <= 1'b0;
            end
        end
    end

    assign cfg_pending  = pend_q;
    assign period_start = ps_q;
    assign pwm_out      = pwm_q;

endmodule
